clock_core_hms: RTL and testbench

Parametrised hours/minutes/seconds timekeeping core for the board clock designs: holds time in 24-hour binary and runs it from a prescaled system clock. It provides a button-driven set mode with field select and auto-repeat, and presents six BCD digits in run-time-selectable 12- or 24-hour format. It feeds the existing six-digit seven-segment driver directly and replaces the fixed 12-hour clock logic.

---
 rtl/clock_core_hms.sv | 177 +++++++++++++++++
 tb/tb_clock_core_hms.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_core_hms.sv
// Hours/minutes/seconds timekeeping core with button-driven set mode, auto-repeat
// and a registered six-digit BCD display in 12- or 24-hour format.
module clock_core_hms #(
  parameter int CLK_HZ        = 100_000_000,
  parameter int REPEAT_CYCLES = 25_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_center,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        fmt_24h,
  output logic [23:0] digits,
  output logic        pm_led,
  output logic        run_led,
  output logic [1:0]  edit_field,
  output logic        sec_pulse
);

  localparam int PW = $clog2(CLK_HZ);
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
  localparam logic [RW-1:0] REP_LAST   = RW'(REPEAT_CYCLES - 1);

  typedef enum logic {
    ST_SET = 1'b0,
    ST_RUN = 1'b1
  } state_e;

  state_e          state_q;
  logic [4:0]      hrs_q;
  logic [5:0]      min_q;
  logic [5:0]      sec_q;
  logic [PW-1:0]   presc_q;
  logic [RW-1:0]   rep_q;
  logic [1:0]      field_q;
  logic [4:0]      btn_q;
  logic            sec_pulse_q;
  logic [23:0]     digits_q;
  logic            pm_q;

  logic [4:0]      btn_now;
  logic [4:0]      press;
  logic            up_only;
  logic            dn_only;
  logic            rep_hit;
  logic            step_up;
  logic            step_dn;
  logic            fld_left;
  logic            fld_right;
  logic [5:0]      hrs_disp_d;
  logic [23:0]     digits_d;
  logic            pm_d;

  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] last);
    return (v == last) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [5:0] wrap_dec(input logic [5:0] v, input logic [5:0] last);
    return (v == 6'd0) ? last : v - 6'd1;
  endfunction

  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [3:0] tens;
    tens = 4'(v / 6'd10);
    return {tens, 4'(v - {2'b00, tens} * 6'd10)};
  endfunction

  // Bit order {center, left, right, up, down}; a press is a rising level.
  assign btn_now   = {btn_center, btn_left, btn_right, btn_up, btn_down};
  assign press     = btn_now & ~btn_q;
  assign up_only   = btn_up & ~btn_down;
  assign dn_only   = btn_down & ~btn_up;
  assign rep_hit   = (rep_q == REP_LAST);
  assign step_up   = up_only & (press[1] | rep_hit);
  assign step_dn   = dn_only & (press[0] | rep_hit);
  assign fld_left  = press[3] & ~press[2];
  assign fld_right = press[2] & ~press[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SET;
      hrs_q       <= 5'd0;
      min_q       <= 6'd0;
      sec_q       <= 6'd0;
      presc_q     <= '0;
      rep_q       <= '0;
      field_q     <= 2'd1;
      btn_q       <= '0;
      sec_pulse_q <= 1'b0;
    end else begin
      btn_q       <= btn_now;
      sec_pulse_q <= 1'b0;
      case (state_q)
        ST_SET: begin
          if (press[4]) begin
            state_q <= ST_RUN;
            sec_q   <= 6'd0;
            presc_q <= '0;
            field_q <= 2'd1;
            rep_q   <= '0;
          end else begin
            if (step_up || step_dn) begin
              case (field_q)
                2'd0:    sec_q <= step_up ? wrap_inc(sec_q, 6'd59) : wrap_dec(sec_q, 6'd59);
                2'd1:    min_q <= step_up ? wrap_inc(min_q, 6'd59) : wrap_dec(min_q, 6'd59);
                2'd2:    hrs_q <= 5'(step_up ? wrap_inc({1'b0, hrs_q}, 6'd23)
                                             : wrap_dec({1'b0, hrs_q}, 6'd23));
                default: ;
              endcase
            end
            // Repeat counter restarts on every step, release, dual-press or field move.
            if (fld_left || fld_right || !(up_only || dn_only) || step_up || step_dn)
              rep_q <= '0;
            else
              rep_q <= rep_q + 1'b1;
            if (fld_left)
              field_q <= (field_q == 2'd2) ? 2'd0 : field_q + 2'd1;
            else if (fld_right)
              field_q <= (field_q == 2'd0) ? 2'd2 : field_q - 2'd1;
          end
        end
        ST_RUN: begin
          if (press[4]) begin
            state_q <= ST_SET;
            presc_q <= '0;
            field_q <= 2'd1;
            rep_q   <= '0;
          end else if (presc_q == PRESC_LAST) begin
            presc_q     <= '0;
            sec_pulse_q <= 1'b1;
            sec_q       <= wrap_inc(sec_q, 6'd59);
            if (sec_q == 6'd59)
              min_q <= wrap_inc(min_q, 6'd59);
            if (sec_q == 6'd59 && min_q == 6'd59)
              hrs_q <= 5'(wrap_inc({1'b0, hrs_q}, 6'd23));
          end else begin
            presc_q <= presc_q + 1'b1;
          end
        end
        default: state_q <= ST_SET;
      endcase
    end
  end

  always_comb begin
    hrs_disp_d = {1'b0, hrs_q};
    if (!fmt_24h) begin
      if (hrs_q == 5'd0)
        hrs_disp_d = 6'd12;
      else if (hrs_q > 5'd12)
        hrs_disp_d = {1'b0, hrs_q} - 6'd12;
    end
    digits_d = {to_bcd(hrs_disp_d), to_bcd(min_q), to_bcd(sec_q)};
    pm_d     = !fmt_24h && (hrs_q >= 5'd12);
  end

  // Display register: one cycle behind the time registers and fmt_24h.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_q <= 24'h120000;
      pm_q     <= 1'b0;
    end else begin
      digits_q <= digits_d;
      pm_q     <= pm_d;
    end
  end

  assign digits     = digits_q;
  assign pm_led     = pm_q;
  assign run_led    = (state_q == ST_RUN);
  assign edit_field = field_q;
  assign sec_pulse  = sec_pulse_q;

endmodule

// File: tb/tb_clock_core_hms.sv
// Self-checking bench for clock_core_hms: directed scenarios plus randomized
// button traffic against a seconds-of-day reference model.
module tb_clock_core_hms;

  localparam int CLK_HZ = 10;
  localparam int REP    = 4;

  localparam logic [4:0] B_0 = 5'b00000;
  localparam logic [4:0] B_C = 5'b10000;
  localparam logic [4:0] B_L = 5'b01000;
  localparam logic [4:0] B_R = 5'b00100;
  localparam logic [4:0] B_U = 5'b00010;
  localparam logic [4:0] B_D = 5'b00001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_center = 1'b0;
  logic        btn_left = 1'b0;
  logic        btn_right = 1'b0;
  logic        btn_up = 1'b0;
  logic        btn_down = 1'b0;
  logic        fmt_24h = 1'b0;
  logic [23:0] digits;
  logic        pm_led;
  logic        run_led;
  logic [1:0]  edit_field;
  logic        sec_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: time as seconds since midnight.
  logic        m_run;
  int          m_t;
  int          m_field;
  int          m_presc;
  int          m_hold;
  logic [4:0]  m_prev;
  logic [23:0] m_disp;
  logic        m_pm;
  logic        m_pulse;

  always #5 clk = ~clk;

  clock_core_hms #(
    .CLK_HZ(CLK_HZ),
    .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_center(btn_center),
    .btn_left(btn_left),
    .btn_right(btn_right),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .fmt_24h(fmt_24h),
    .digits(digits),
    .pm_led(pm_led),
    .run_led(run_led),
    .edit_field(edit_field),
    .sec_pulse(sec_pulse)
  );

  function automatic logic [23:0] disp_of(input int t, input logic f24);
    int h, m, s, hd;
    h  = t / 3600;
    m  = (t / 60) % 60;
    s  = t % 60;
    hd = f24 ? h : ((h % 12 == 0) ? 12 : h % 12);
    return {4'(hd / 10), 4'(hd % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic model_reset();
    m_run = 1'b0; m_t = 0; m_field = 1; m_presc = 0; m_hold = 0;
    m_prev = '0; m_disp = 24'h120000; m_pm = 1'b0; m_pulse = 1'b0;
  endtask

  task automatic model_edge(input logic [4:0] b, input logic f24);
    logic [4:0]  p;
    logic [23:0] nd;
    logic        npm;
    int          dir, h, m, s;
    p   = b & ~m_prev;
    nd  = disp_of(m_t, f24);
    npm = !f24 && (m_t >= 12 * 3600);
    m_pulse = 1'b0;
    dir = 0;
    if (p[4]) begin
      m_run = !m_run; m_presc = 0; m_field = 1; m_hold = 0;
      if (m_run) m_t = m_t - (m_t % 60);
    end else if (m_run) begin
      if (m_presc == CLK_HZ - 1) begin
        m_presc = 0; m_t = (m_t + 1) % 86400; m_pulse = 1'b1;
      end else begin
        m_presc++;
      end
    end else begin
      if (b[1] != b[0]) begin
        if ((b[1] && p[1]) || (b[0] && p[0])) begin
          m_hold = 0; dir = b[1] ? 1 : -1;
        end else begin
          m_hold++;
          if (m_hold % REP == 0) dir = b[1] ? 1 : -1;
        end
      end else begin
        m_hold = 0;
      end
      if (dir != 0) begin
        h = m_t / 3600; m = (m_t / 60) % 60; s = m_t % 60;
        case (m_field)
          0:       s = (s + dir + 60) % 60;
          1:       m = (m + dir + 60) % 60;
          default: h = (h + dir + 24) % 24;
        endcase
        m_t = h * 3600 + m * 60 + s;
      end
      if (p[3] && !p[2]) begin
        m_field = (m_field + 1) % 3; m_hold = 0;
      end else if (p[2] && !p[3]) begin
        m_field = (m_field + 2) % 3; m_hold = 0;
      end
    end
    m_prev = b; m_disp = nd; m_pm = npm;
  endtask

  // One clock: drive at the falling edge, step the model at the rising edge, settle.
  task automatic cyc(input logic [4:0] b);
    @(negedge clk);
    {btn_center, btn_left, btn_right, btn_up, btn_down} = b;
    @(posedge clk);
    model_edge(b, fmt_24h);
    #1;
  endtask

  task automatic tap(input logic [4:0] b, input int n);
    repeat (n) begin
      cyc(b);
      cyc(B_0);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    {btn_center, btn_left, btn_right, btn_up, btn_down} = B_0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    fmt_24h = 1'b0;
    do_reset();
    n_checks++; if (digits !== 24'h120000) begin n_fail++; $display("FAIL reset_digits got=%h exp=120000", digits); end
    n_checks++; if (pm_led !== 1'b0) begin n_fail++; $display("FAIL reset_pm got=%b exp=0", pm_led); end
    n_checks++; if (run_led !== 1'b0) begin n_fail++; $display("FAIL reset_run got=%b exp=0", run_led); end
    n_checks++; if (edit_field !== 2'd1) begin n_fail++; $display("FAIL reset_field got=%0d exp=1", edit_field); end
    n_checks++; if (sec_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse got=%b exp=0", sec_pulse); end
    cyc(B_0);
    cyc(B_0);
    n_checks++; if (digits !== 24'h120000) begin n_fail++; $display("FAIL reset_idle_digits got=%h exp=120000", digits); end
    tap(B_C, 1);
    repeat (23) cyc(B_0);
    n_checks++; if (run_led !== 1'b1) begin n_fail++; $display("FAIL reset_prerun got=%b exp=1", run_led); end
    n_checks++; if (digits !== 24'h120002) begin n_fail++; $display("FAIL reset_prerun_digits got=%h exp=120002", digits); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (digits !== 24'h120000) begin n_fail++; $display("FAIL midrun_rst_digits got=%h exp=120000", digits); end
    n_checks++; if (run_led !== 1'b0) begin n_fail++; $display("FAIL midrun_rst_run got=%b exp=0", run_led); end
    n_checks++; if (edit_field !== 2'd1) begin n_fail++; $display("FAIL midrun_rst_field got=%0d exp=1", edit_field); end
    n_checks++; if (pm_led !== 1'b0 || sec_pulse !== 1'b0) begin n_fail++; $display("FAIL midrun_rst_leds got=%b%b exp=00", pm_led, sec_pulse); end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_rollover();
    int pulses;
    fmt_24h = 1'b1;
    do_reset();
    tap(B_L, 1); tap(B_D, 1);
    tap(B_R, 1); tap(B_D, 1);
    tap(B_R, 1); tap(B_D, 1);
    n_checks++; if (digits !== 24'h235959) begin n_fail++; $display("FAIL roll_set got=%h exp=235959", digits); end
    n_checks++; if (edit_field !== 2'd0) begin n_fail++; $display("FAIL roll_field got=%0d exp=0", edit_field); end
    cyc(B_C);
    n_checks++; if (run_led !== 1'b1) begin n_fail++; $display("FAIL roll_run got=%b exp=1", run_led); end
    pulses = 0;
    for (int k = 1; k <= 60 * CLK_HZ; k++) begin
      cyc(B_0);
      if (k == 1) begin
        n_checks++; if (digits !== 24'h235900) begin n_fail++; $display("FAIL roll_commit got=%h exp=235900", digits); end
      end
      n_checks++;
      if (sec_pulse !== (k % CLK_HZ == 0)) begin
        n_fail++; $display("FAIL roll_pulse k=%0d got=%b exp=%b", k, sec_pulse, (k % CLK_HZ == 0));
      end
      if (sec_pulse === 1'b1) pulses++;
    end
    cyc(B_0);
    n_checks++; if (digits !== 24'h000000) begin n_fail++; $display("FAIL roll_midnight got=%h exp=000000", digits); end
    n_checks++; if (pulses != 60) begin n_fail++; $display("FAIL roll_count got=%0d exp=60", pulses); end
  endtask

  task automatic test_12h();
    int         hv[5]  = '{0, 11, 12, 13, 23};
    logic [7:0] e12[5] = '{8'h12, 8'h11, 8'h12, 8'h01, 8'h11};
    logic       ep[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] e24[5] = '{8'h00, 8'h11, 8'h12, 8'h13, 8'h23};
    int         cur;
    fmt_24h = 1'b0;
    do_reset();
    tap(B_L, 1);
    cur = 0;
    for (int i = 0; i < 5; i++) begin
      fmt_24h = 1'b0;
      tap(B_U, hv[i] - cur);
      cur = hv[i];
      cyc(B_0);
      n_checks++; if (digits !== {e12[i], 16'h0000}) begin n_fail++; $display("FAIL h12_digits h=%0d got=%h exp=%h0000", hv[i], digits, e12[i]); end
      n_checks++; if (pm_led !== ep[i]) begin n_fail++; $display("FAIL h12_pm h=%0d got=%b exp=%b", hv[i], pm_led, ep[i]); end
      fmt_24h = 1'b1;
      cyc(B_0);
      n_checks++; if (digits[23:16] !== e24[i]) begin n_fail++; $display("FAIL h24_digits h=%0d got=%h exp=%h", hv[i], digits[23:16], e24[i]); end
      n_checks++; if (pm_led !== 1'b0) begin n_fail++; $display("FAIL h24_pm h=%0d got=%b exp=0", hv[i], pm_led); end
    end
  endtask

  task automatic test_field_wrap();
    fmt_24h = 1'b1;
    do_reset();
    tap(B_L, 1); tap(B_U, 5); tap(B_R, 1);
    n_checks++; if (edit_field !== 2'd1) begin n_fail++; $display("FAIL wrap_field got=%0d exp=1", edit_field); end
    tap(B_D, 1);
    n_checks++; if (digits !== 24'h055900) begin n_fail++; $display("FAIL wrap_min_down got=%h exp=055900", digits); end
    tap(B_L, 1); tap(B_D, 6);
    n_checks++; if (digits !== 24'h235900) begin n_fail++; $display("FAIL wrap_hrs_down got=%h exp=235900", digits); end
    tap(B_U, 1);
    n_checks++; if (digits !== 24'h005900) begin n_fail++; $display("FAIL wrap_hrs_up got=%h exp=005900", digits); end
  endtask

  task automatic test_autorepeat();
    fmt_24h = 1'b1;
    do_reset();
    tap(B_U, 10);
    n_checks++; if (digits !== 24'h001000) begin n_fail++; $display("FAIL rep_start got=%h exp=001000", digits); end
    repeat (13) cyc(B_U);
    cyc(B_0);
    n_checks++; if (digits !== 24'h001400) begin n_fail++; $display("FAIL rep_up_hold got=%h exp=001400", digits); end
    repeat (9) cyc(B_U | B_D);
    cyc(B_0);
    n_checks++; if (digits !== 24'h001400) begin n_fail++; $display("FAIL rep_both got=%h exp=001400", digits); end
    repeat (5) cyc(B_D);
    cyc(B_0);
    n_checks++; if (digits !== 24'h001200) begin n_fail++; $display("FAIL rep_down_hold got=%h exp=001200", digits); end
  endtask

  task automatic test_midtick();
    int first;
    fmt_24h = 1'b1;
    do_reset();
    cyc(B_C);
    repeat (15) cyc(B_0);
    cyc(B_C);
    n_checks++; if (run_led !== 1'b0) begin n_fail++; $display("FAIL mid_set got=%b exp=0", run_led); end
    tap(B_U, 1);
    n_checks++; if (digits !== 24'h000101) begin n_fail++; $display("FAIL mid_edit got=%h exp=000101", digits); end
    cyc(B_C);
    first = -1;
    for (int k = 1; k <= 3 * CLK_HZ; k++) begin
      cyc(B_0);
      if (k == 1) begin
        n_checks++; if (digits !== 24'h000100) begin n_fail++; $display("FAIL mid_commit got=%h exp=000100", digits); end
      end
      if (sec_pulse === 1'b1 && first < 0) first = k;
    end
    n_checks++; if (first != CLK_HZ) begin n_fail++; $display("FAIL mid_first_tick got=%0d exp=%0d", first, CLK_HZ); end
  endtask

  task automatic test_random();
    logic [4:0]  b;
    logic [29:0] got, exp;
    int          cycles, r, len;
    fmt_24h = 1'($urandom_range(0, 1));
    do_reset();
    cycles = 0;
    while (cycles < 4000) begin
      r = $urandom_range(0, 99);
      if (r < 4)       b = B_C;
      else if (r < 12) b = B_L;
      else if (r < 20) b = B_R;
      else if (r < 23) b = B_L | B_R;
      else if (r < 30) b = B_U | B_D;
      else if (r < 50) b = B_U;
      else if (r < 70) b = B_D;
      else             b = B_0;
      len = $urandom_range(1, 9);
      if ($urandom_range(0, 15) == 0) fmt_24h = ~fmt_24h;
      repeat (len) begin
        cyc(b);
        cycles++;
        got = {digits, pm_led, run_led, edit_field, sec_pulse};
        exp = {m_disp, m_pm, m_run, 2'(m_field), m_pulse};
        n_checks++;
        if (got !== exp) begin
          n_fail++; $display("FAIL random cyc=%0d got=%h exp=%h", cycles, got, exp);
        end
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    test_reset();
    test_rollover();
    test_12h();
    test_field_wrap();
    test_autorepeat();
    test_midtick();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
